aes_shiftmix_col: RTL and testbench

Round stage directly downstream of the 16-byte SubBytes register stage in the AES core. On a start pulse it registers ShiftRows(state_i), then applies MixColumns one 32-bit column per cycle over four cycles, sharing a single column mixer. It presents the finished 128-bit state with a one-cycle done pulse. A last-round control bypasses MixColumns, per FIPS-197 final round, so one block serves every encryption round.

---
 rtl/aes_shiftmix_col_if.sv | 29 ++
 rtl/aes_shiftmix_col.sv | 128 ++++++++++++
 tb/tb_aes_shiftmix_col.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_shiftmix_col_if.sv
// Handshake and data bundle between the SubBytes stage and the ShiftRows/MixColumns stage.
//   en_i          start strobe (from the SubBytes stage done_o)
//   last_round_i  1 = ShiftRows only, skip MixColumns
//   state_i       128-bit state after SubBytes
//   busy_o        block in progress
//   done_o        one-cycle pulse when state_o takes a new result
//   state_o       registered 128-bit result
interface aes_shiftmix_col_if;
    localparam int unsigned STATE_W = 128;

    logic               en_i;
    logic               last_round_i;
    logic [STATE_W-1:0] state_i;
    logic               busy_o;
    logic               done_o;
    logic [STATE_W-1:0] state_o;

    // Upstream side: drives the start strobe and the state.
    modport master (
        output en_i, last_round_i, state_i,
        input  busy_o, done_o, state_o
    );

    // Stage side.
    modport slave (
        input  en_i, last_round_i, state_i,
        output busy_o, done_o, state_o
    );
endinterface

// File: rtl/aes_shiftmix_col.sv
// AES round stage: ShiftRows on accept, then MixColumns one column per cycle through a
// single shared column mixer; last_round_i bypasses the mixer but keeps the same latency.
//   clk_i  clock (rising edge)
//   rst_n  asynchronous active-low reset
//   bus    aes_shiftmix_col_if.slave (en_i, last_round_i, state_i, busy_o, done_o, state_o)
module aes_shiftmix_col (
    input  logic                 clk_i,
    input  logic                 rst_n,
    aes_shiftmix_col_if.slave    bus
);
    localparam int unsigned STATE_W = 128;
    localparam int unsigned COL_W   = 32;
    localparam int unsigned CNT_W   = 2;
    localparam int unsigned IDX_W   = 7;

    typedef enum logic {IDLE, RUN} fsm_t;

    fsm_t               state_q, state_d;
    logic [STATE_W-1:0] work_q, work_d;
    logic [STATE_W-1:0] acc_q, acc_d;
    logic [STATE_W-1:0] res_q, res_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               lr_q, lr_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic [IDX_W-1:0]   col_idx;
    logic [COL_W-1:0]   col_in;
    logic [COL_W-1:0]   col_new;

    // GF(2^8) multiply by 2.
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    endfunction

    // MixColumns on one column; a0 (row 0) is the most significant byte.
    function automatic logic [COL_W-1:0] mix_col(input logic [COL_W-1:0] c);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] d0, d1, d2, d3;
        {a0, a1, a2, a3} = c;
        d0 = xtime(a0);
        d1 = xtime(a1);
        d2 = xtime(a2);
        d3 = xtime(a3);
        return {d0 ^ d1 ^ a1 ^ a2 ^ a3,
                a0 ^ d1 ^ d2 ^ a2 ^ a3,
                a0 ^ a1 ^ d2 ^ d3 ^ a3,
                d0 ^ a0 ^ a1 ^ a2 ^ d3};
    endfunction

    // Row r rotates left by r; bytes are column-major with s(0,0) in the top byte.
    function automatic logic [STATE_W-1:0] shift_rows(input logic [STATE_W-1:0] s);
        logic [STATE_W-1:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    // Column c lives at bit offset 32*(3-c); ~cnt_q equals 3-cnt_q for a 2-bit counter.
    assign col_idx = {~cnt_q, 5'd0};
    assign col_in  = work_q[col_idx +: COL_W];
    assign col_new = lr_q ? col_in : mix_col(col_in);

    // Next-state and datapath control.
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        acc_d   = acc_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        lr_d    = lr_q;
        done_d  = 1'b0;
        busy_d  = busy_q;
        case (state_q)
            IDLE: begin
                if (bus.en_i) begin
                    work_d  = shift_rows(bus.state_i);
                    lr_d    = bus.last_round_i;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d[col_idx +: COL_W] = col_new;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(3)) begin
                    // Publish the whole state at once so state_o is never partially mixed.
                    res_d   = {acc_q[STATE_W-1:COL_W], col_new};
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            work_q  <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            lr_q    <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            lr_q    <= lr_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.busy_o  = busy_q;
    assign bus.done_o  = done_q;
    assign bus.state_o = res_q;
endmodule

// File: tb/tb_aes_shiftmix_col.sv
// Self-checking bench for aes_shiftmix_col: expected results are queued with their due
// cycle when a block is started and checked when done_o pulses.
module tb_aes_shiftmix_col;
    logic clk_i = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk_i = ~clk_i;

    aes_shiftmix_col_if bus ();
    aes_shiftmix_col dut (.clk_i(clk_i), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [127:0] data;
        int           due;
    } exp_t;

    exp_t         q[$];
    int           n_checks = 0;
    int           n_fail   = 0;
    int           cyc      = 0;
    logic [127:0] last_exp = '0;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Reference model: byte-array ShiftRows plus generic GF(2^8) matrix multiply.
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1B) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] in, input logic lr);
        logic [7:0]   s[4][4];
        logic [7:0]   t[4][4];
        logic [7:0]   m[4][4];
        logic [7:0]   coef[4][4];
        logic [127:0] o;
        coef = '{'{8'h02, 8'h03, 8'h01, 8'h01},
                 '{8'h01, 8'h02, 8'h03, 8'h01},
                 '{8'h01, 8'h01, 8'h02, 8'h03},
                 '{8'h03, 8'h01, 8'h01, 8'h02}};
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[r][c] = in[127-8*(4*c+r) -: 8];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[r][c] = s[r][(c+r)%4];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                m[r][c] = 8'h00;
                for (int k = 0; k < 4; k++) m[r][c] = m[r][c] ^ gmul(coef[r][k], t[k][c]);
            end
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = lr ? t[r][c] : m[r][c];
        return o;
    endfunction

    // Scoreboard monitor: result and latency on done_o, hold of state_o otherwise.
    always @(negedge clk_i) begin
        exp_t e;
        if (rst_n === 1'b1) begin
            if (bus.done_o === 1'b1) begin
                if (q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL spurious_done: done_o=1 at cycle %0d, required 0", cyc);
                end else begin
                    e = q.pop_front();
                    n_checks++;
                    if (bus.state_o !== e.data) begin
                        n_fail++;
                        $display("FAIL result: state_o=%h required %h", bus.state_o, e.data);
                    end
                    n_checks++;
                    if (cyc !== e.due) begin
                        n_fail++;
                        $display("FAIL latency: done_o at cycle %0d required %0d", cyc, e.due);
                    end
                    last_exp = e.data;
                end
            end else begin
                n_checks++;
                if (bus.state_o !== last_exp) begin
                    n_fail++;
                    $display("FAIL hold: state_o=%h required %h", bus.state_o, last_exp);
                end
            end
        end
    end

    // Drive a one-cycle start at a negedge while IDLE; done is due on the 4th edge after accept.
    task automatic start_block(input logic [127:0] data, input logic lr, input logic [127:0] exp);
        exp_t e;
        bus.en_i         = 1'b1;
        bus.state_i      = data;
        bus.last_round_i = lr;
        e.data = exp;
        e.due  = cyc + 5;
        q.push_back(e);
        @(negedge clk_i);
        bus.en_i = 1'b0;
    endtask

    task automatic wait_drain(input int bound);
        int n;
        n = 0;
        while (q.size() != 0 && n < bound) begin
            @(negedge clk_i);
            n++;
        end
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", q.size());
            q.delete();
        end
        @(negedge clk_i);
    endtask

    task automatic test_reset();
        bus.en_i = 1'b0; bus.last_round_i = 1'b0; bus.state_i = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk_i);
        n_checks++;
        if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: busy_o=%b required 0", bus.busy_o); end
        n_checks++;
        if (bus.done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done: done_o=%b required 0", bus.done_o); end
        n_checks++;
        if (bus.state_o !== 128'h0) begin n_fail++; $display("FAIL reset_state: state_o=%h required 0", bus.state_o); end
        last_exp = '0;
        rst_n = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_full_round();
        start_block(128'hd42711aee0bf98f1b8b45de51e415230, 1'b0, 128'h046681e5e0cb199a48f8d37a2806264c);
        n_checks++;
        if (bus.busy_o !== 1'b1) begin n_fail++; $display("FAIL busy_after_accept: busy_o=%b required 1", bus.busy_o); end
        wait_drain(20);
        n_checks++;
        if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL busy_after_done: busy_o=%b required 0", bus.busy_o); end
    endtask

    task automatic test_final_round();
        start_block(128'hd42711aee0bf98f1b8b45de51e415230, 1'b1, 128'hd4bf5d30e0b452aeb84111f11e2798e5);
        wait_drain(20);
    endtask

    // Identical columns survive ShiftRows, so each column is the value under test.
    task automatic test_mixer();
        logic [31:0] vin[3];
        logic [31:0] vout[3];
        vin  = '{32'hdb135345, 32'hf20a225c, 32'h01010101};
        vout = '{32'h8e4da1bc, 32'h9fdc589d, 32'h01010101};
        for (int i = 0; i < 3; i++) begin
            start_block({4{vin[i]}}, 1'b0, {4{vout[i]}});
            wait_drain(20);
        end
    endtask

    task automatic test_random();
        logic [127:0] d;
        logic         lr;
        for (int i = 0; i < 6; i++) begin
            d  = {$urandom, $urandom, $urandom, $urandom};
            lr = 1'($urandom_range(0, 1));
            start_block(d, lr, model(d, lr));
            wait_drain(20);
        end
    endtask

    // en_i held high: accepts every 5 cycles, done pulses in between, en_i during RUN ignored.
    task automatic test_back_to_back();
        logic [31:0] vin[3];
        logic [31:0] vout[3];
        exp_t        e;
        vin  = '{32'hdb135345, 32'hf20a225c, 32'h01010101};
        vout = '{32'h8e4da1bc, 32'h9fdc589d, 32'h01010101};
        bus.en_i = 1'b1;
        bus.last_round_i = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (i % 5 == 0) begin
                bus.state_i = {4{vin[i/5]}};
                e.data = {4{vout[i/5]}};
                e.due  = cyc + 5;
                q.push_back(e);
            end
            @(negedge clk_i);
        end
        bus.en_i = 1'b0;
        wait_drain(20);
    endtask

    task automatic test_reset_mid();
        start_block(128'hd42711aee0bf98f1b8b45de51e415230, 1'b0, 128'h046681e5e0cb199a48f8d37a2806264c);
        repeat (2) @(negedge clk_i);
        rst_n = 1'b0;
        last_exp = '0;
        q.delete();
        #1;
        n_checks++;
        if (bus.state_o !== 128'h0) begin n_fail++; $display("FAIL midreset_state: state_o=%h required 0", bus.state_o); end
        n_checks++;
        if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: busy_o=%b required 0", bus.busy_o); end
        n_checks++;
        if (bus.done_o !== 1'b0) begin n_fail++; $display("FAIL midreset_done: done_o=%b required 0", bus.done_o); end
        repeat (3) @(negedge clk_i);
        rst_n = 1'b1;
        repeat (6) @(negedge clk_i);
        start_block(128'hd42711aee0bf98f1b8b45de51e415230, 1'b1, 128'hd4bf5d30e0b452aeb84111f11e2798e5);
        wait_drain(20);
    endtask

    task automatic test_hold();
        int pulses;
        pulses = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk_i);
            if (bus.done_o !== 1'b0) pulses++;
        end
        n_checks++;
        if (pulses != 0) begin n_fail++; $display("FAIL hold_done: %0d done pulses, required 0", pulses); end
        n_checks++;
        if (bus.state_o !== 128'hd4bf5d30e0b452aeb84111f11e2798e5) begin
            n_fail++;
            $display("FAIL hold_state: state_o=%h required d4bf5d30e0b452aeb84111f11e2798e5", bus.state_o);
        end
    endtask

    initial begin
        @(negedge clk_i);
        test_reset();
        test_full_round();
        test_final_round();
        test_mixer();
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end
endmodule
